// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the pc_sequencer and the CPU instruction port.
// The master (CPU/decoder side) drives the stall and the redirect request.
// The slave (sequencer side) returns the fetch PC, link address, status and count.
interface pc_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic                stall;
    logic                redirect_valid;
    logic [31:0]         redirect_target;
    logic [31:0]         instr_address;
    logic [31:0]         link_address;
    logic                in_delay_slot;
    logic                active;
    logic                addr_error;
    logic                slot_error;
    logic [COUNT_W-1:0]  fetch_count;

    modport master (
        output stall,
        output redirect_valid,
        output redirect_target,
        input  instr_address,
        input  link_address,
        input  in_delay_slot,
        input  active,
        input  addr_error,
        input  slot_error,
        input  fetch_count
    );

    modport slave (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output instr_address,
        output link_address,
        output in_delay_slot,
        output active,
        output addr_error,
        output slot_error,
        output fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage with MIPS branch-delay-slot sequencing.
// A redirect seen at PC=A produces the fetch sequence A, A+4, target.
// Reaching HALT_ADDR, or wrapping sequentially past the top of memory, halts the stage.
// Once halted, all state stays frozen until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
    parameter int          COUNT_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_enable,
    pc_sequencer_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [31:0]          pc_r, pc_nxt_s;
    logic                 pending_r, pending_nxt_s;
    logic [31:0]          target_r, target_nxt_s;
    logic                 addr_err_r, addr_err_nxt_s;
    logic                 slot_err_r, slot_err_nxt_s;
    logic [COUNT_W-1:0]   count_r, count_nxt_s;

    logic                 active_s;
    logic                 advance_s;
    logic [31:0]          seq_pc_s;
    logic [31:0]          next_pc_s;
    logic                 wrap_s;
    logic                 halt_s;

    assign active_s  = (state_r == ST_RUN);
    assign advance_s = clk_enable & ~bus.stall & active_s;
    assign seq_pc_s  = pc_r + 32'd4;
    assign next_pc_s = pending_r ? target_r : seq_pc_s;
    // Sequential fall-off from the last word counts as a halt even if HALT_ADDR is non-zero.
    assign wrap_s    = ~pending_r & (pc_r == 32'hFFFF_FFFC);
    assign halt_s    = (next_pc_s == HALT_ADDR) | wrap_s;

    // Next-state and next-value logic for PC, delay-slot tracking, errors, counter and run state.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        pending_nxt_s  = pending_r;
        target_nxt_s   = target_r;
        addr_err_nxt_s = addr_err_r;
        slot_err_nxt_s = slot_err_r;
        count_nxt_s    = count_r;

        case (state_r)
            ST_RUN: begin
                if (advance_s) begin
                    pc_nxt_s    = next_pc_s;
                    count_nxt_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
                    if (halt_s) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                    if (pending_r) begin
                        // Delay slot retires: the pending target wins over any new redirect.
                        pending_nxt_s = 1'b0;
                        if (bus.redirect_valid) begin
                            slot_err_nxt_s = 1'b1;
                        end else begin
                            slot_err_nxt_s = slot_err_r;
                        end
                    end else if (bus.redirect_valid) begin
                        pending_nxt_s = 1'b1;
                        target_nxt_s  = {bus.redirect_target[31:2], 2'b00};
                        if (bus.redirect_target[1:0] != 2'b00) begin
                            addr_err_nxt_s = 1'b1;
                        end else begin
                            addr_err_nxt_s = addr_err_r;
                        end
                    end else begin
                        pending_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over enable and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_VECTOR;
            pending_r  <= 1'b0;
            target_r   <= 32'h0000_0000;
            addr_err_r <= 1'b0;
            slot_err_r <= 1'b0;
            count_r    <= {COUNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            pending_r  <= pending_nxt_s;
            target_r   <= target_nxt_s;
            addr_err_r <= addr_err_nxt_s;
            slot_err_r <= slot_err_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

    assign bus.instr_address = pc_r;
    assign bus.link_address  = pc_r + 32'd8;
    assign bus.in_delay_slot = pending_r;
    assign bus.active        = active_s;
    assign bus.addr_error    = addr_err_r;
    assign bus.slot_error    = slot_err_r;
    assign bus.fetch_count   = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential fetch, delay-slot redirects,
// stall/enable holds, double redirect errors, reset mid-slot, halt and wrap.
module tb_pc_sequencer;

    logic clk;
    logic reset;
    logic clk_enable;
    int   tests;
    int   failed;

    pc_sequencer_if #(.COUNT_W(32)) bus_if ();

    pc_sequencer #(
        .RESET_VECTOR (32'hBFC0_0000),
        .HALT_ADDR    (32'h0000_0000),
        .COUNT_W      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return on the falling edge for sampling and driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks PC, delay-slot flag, active and fetch count in one go.
    task automatic chk_state(input string tag, input logic [31:0] pc, input logic ds,
                             input logic act, input logic [31:0] cnt);
        chk({tag, "_pc"},  bus_if.instr_address, pc);
        chk({tag, "_ds"},  {31'd0, bus_if.in_delay_slot}, {31'd0, ds});
        chk({tag, "_act"}, {31'd0, bus_if.active}, {31'd0, act});
        chk({tag, "_cnt"}, bus_if.fetch_count, cnt);
    endtask

    task automatic chk_err(input string tag, input logic aerr, input logic serr);
        chk({tag, "_aerr"}, {31'd0, bus_if.addr_error}, {31'd0, aerr});
        chk({tag, "_serr"}, {31'd0, bus_if.slot_error}, {31'd0, serr});
    endtask

    initial begin
        tests                  = 0;
        failed                 = 0;
        reset                  = 1'b1;
        clk_enable             = 1'b1;
        bus_if.stall           = 1'b0;
        bus_if.redirect_valid  = 1'b0;
        bus_if.redirect_target = 32'h0000_0000;

        // Reset held for two cycles.
        cyc();
        cyc();
        chk_state("rst", 32'hBFC0_0000, 1'b0, 1'b1, 32'd0);
        chk_err("rst", 1'b0, 1'b0);
        chk("rst_link", bus_if.link_address, 32'hBFC0_0008);

        // Sequential fetch.
        reset = 1'b0;
        cyc();
        chk_state("seq1", 32'hBFC0_0004, 1'b0, 1'b1, 32'd1);
        cyc();
        chk_state("seq2", 32'hBFC0_0008, 1'b0, 1'b1, 32'd2);

        // Redirect from the reset vector with one delay slot.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("br_link", bus_if.link_address, 32'hBFC0_0008);
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_000C;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("br_slot", 32'hBFC0_0004, 1'b1, 1'b1, 32'd1);
        chk("br_slot_link", bus_if.link_address, 32'hBFC0_000C);
        cyc();
        chk_state("br_tgt", 32'hBFC0_000C, 1'b0, 1'b1, 32'd2);
        chk_err("br_tgt", 1'b0, 1'b0);

        // Stall for three cycles inside a delay slot.
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_0040;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("stl_slot", 32'hBFC0_0010, 1'b1, 1'b1, 32'd3);
        bus_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_state("stl_hold", 32'hBFC0_0010, 1'b1, 1'b1, 32'd3);
        end
        bus_if.stall = 1'b0;
        cyc();
        chk_state("stl_tgt", 32'hBFC0_0040, 1'b0, 1'b1, 32'd4);
        chk_err("stl_tgt", 1'b0, 1'b0);

        // clk_enable low inside a delay slot.
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_0080;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("ce_slot", 32'hBFC0_0044, 1'b1, 1'b1, 32'd5);
        clk_enable = 1'b0;
        cyc();
        chk_state("ce_hold", 32'hBFC0_0044, 1'b1, 1'b1, 32'd5);
        clk_enable = 1'b1;
        cyc();
        chk_state("ce_tgt", 32'hBFC0_0080, 1'b0, 1'b1, 32'd6);

        // Misaligned redirect followed by a redirect in the delay slot.
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_0012;
        cyc();
        chk_state("dbl_slot", 32'hBFC0_0084, 1'b1, 1'b1, 32'd7);
        chk_err("dbl_slot", 1'b1, 1'b0);
        bus_if.redirect_target = 32'hBFC0_0100;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("dbl_tgt", 32'hBFC0_0010, 1'b0, 1'b1, 32'd8);
        chk_err("dbl_tgt", 1'b1, 1'b1);
        cyc();
        chk_state("dbl_next", 32'hBFC0_0014, 1'b0, 1'b1, 32'd9);
        chk_err("dbl_sticky", 1'b1, 1'b1);

        // Reset while a redirect is pending.
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_0200;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("rds_slot", 32'hBFC0_0018, 1'b1, 1'b1, 32'd10);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_state("rds_rst", 32'hBFC0_0000, 1'b0, 1'b1, 32'd0);
        chk_err("rds_rst", 1'b0, 1'b0);

        // Walk to BFC00020 and jump to the halt address.
        for (int i = 0; i < 8; i++) begin
            cyc();
        end
        chk_state("hlt_pre", 32'hBFC0_0020, 1'b0, 1'b1, 32'd8);
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'h0000_0000;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("hlt_slot", 32'hBFC0_0024, 1'b1, 1'b1, 32'd9);
        cyc();
        chk_state("hlt", 32'h0000_0000, 1'b0, 1'b0, 32'd10);
        chk("hlt_link", bus_if.link_address, 32'h0000_0008);
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hBFC0_0000;
        cyc();
        cyc();
        bus_if.redirect_valid  = 1'b0;
        chk_state("hlt_frz", 32'h0000_0000, 1'b0, 1'b0, 32'd10);
        chk_err("hlt_frz", 1'b0, 1'b0);

        // Sequential wrap off the top of the address space halts.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus_if.redirect_valid  = 1'b1;
        bus_if.redirect_target = 32'hFFFF_FFF8;
        cyc();
        bus_if.redirect_valid  = 1'b0;
        cyc();
        chk_state("wrp_a", 32'hFFFF_FFF8, 1'b0, 1'b1, 32'd2);
        chk("wrp_link", bus_if.link_address, 32'h0000_0000);
        cyc();
        chk_state("wrp_b", 32'hFFFF_FFFC, 1'b0, 1'b1, 32'd3);
        chk("wrp_link2", bus_if.link_address, 32'h0000_0004);
        cyc();
        chk_state("wrp_hlt", 32'h0000_0000, 1'b0, 1'b0, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
